// File: rtl/weight_mem_reader.sv
// Weight SRAM burst reader: on a weight_buffer request, streams a mode-dependent
// number of 64-bit words from the weight SRAM with a persistent read pointer.
package weight_mem_reader_pkg;
    typedef enum logic [1:0] {
        MODE_NONE = 2'd0,
        MODE1     = 2'd1,
        MODE2     = 2'd2,
        MODE3     = 2'd3
    } op_mode_e;
endpackage

module weight_mem_reader
    import weight_mem_reader_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int WORDS_MODE1 = 88,
    parameter int WORDS_MODE2 = 44,
    parameter int WORDS_MODE3 = 22
) (
    input  logic              clk,
    input  logic              rst_n,
    input  op_mode_e          mode_in,
    input  logic              mem_req,
    input  logic              load_base,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              flush,
    output logic              sram_rd_en,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [63:0]       sram_rdata,
    output logic              mem_data_valid,
    output logic [63:0]       weight_data,
    output logic              busy,
    output logic              burst_done
);

    localparam int MAX_12    = (WORDS_MODE1 > WORDS_MODE2) ? WORDS_MODE1 : WORDS_MODE2;
    localparam int MAX_WORDS = (MAX_12 > WORDS_MODE3) ? MAX_12 : WORDS_MODE3;
    localparam int CNT_W     = $clog2(MAX_WORDS + 1);

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, DONE, WAIT_REL} state_e;

    state_e            state;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] start_q;
    logic [CNT_W-1:0]  burst_len;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  deliv_cnt;
    logic              rd_en_q;
    logic              rd_pend;

    logic [CNT_W-1:0]  req_len;
    logic [ADDR_W-1:0] start_addr;
    logic              abort;

    // NOTE: every combinational output gets a default before the case so no latch is inferred.
    always_comb begin
        req_len = '0;
        case (mode_in)
            MODE1:   req_len = CNT_W'(WORDS_MODE1);
            MODE2:   req_len = CNT_W'(WORDS_MODE2);
            MODE3:   req_len = CNT_W'(WORDS_MODE3);
            default: req_len = '0;
        endcase
    end

    assign start_addr = load_base ? base_addr : rd_ptr;
    assign abort      = flush && (state == FETCH || state == DRAIN);
    // Flush must kill the read strobe in the cycle it arrives, so it gates the registered enable.
    assign sram_rd_en = rd_en_q && !abort;
    assign busy       = (state == FETCH) || (state == DRAIN) || (state == DONE);

    // NOTE: all state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            rd_ptr         <= '0;
            start_q        <= '0;
            burst_len      <= '0;
            issue_cnt      <= '0;
            deliv_cnt      <= '0;
            rd_en_q        <= 1'b0;
            rd_pend        <= 1'b0;
            sram_addr      <= '0;
            mem_data_valid <= 1'b0;
            weight_data    <= '0;
            burst_done     <= 1'b0;
        end else begin
            // Two-stage return path: strobe -> SRAM data -> registered weight word.
            rd_pend        <= sram_rd_en;
            mem_data_valid <= rd_pend && !abort;
            burst_done     <= 1'b0;
            if (rd_pend && !abort) begin
                weight_data <= sram_rdata;
                deliv_cnt   <= deliv_cnt + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (load_base) rd_ptr <= base_addr;
                    if (mem_req) begin
                        burst_len <= req_len;
                        start_q   <= start_addr;
                        sram_addr <= start_addr;
                        issue_cnt <= '0;
                        deliv_cnt <= '0;
                        if (req_len == '0) begin
                            state      <= DONE;
                            burst_done <= 1'b1;
                        end else begin
                            rd_en_q <= 1'b1;
                            state   <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (abort) begin
                        rd_en_q <= 1'b0;
                        state   <= WAIT_REL;
                    end else begin
                        issue_cnt <= issue_cnt + CNT_W'(1);
                        if (issue_cnt == burst_len - CNT_W'(1)) begin
                            rd_en_q <= 1'b0;
                            state   <= DRAIN;
                        end else begin
                            sram_addr <= sram_addr + ADDR_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        state <= WAIT_REL;
                    end else if (rd_pend && deliv_cnt == burst_len - CNT_W'(1)) begin
                        state      <= DONE;
                        burst_done <= 1'b1;
                    end
                end
                DONE: begin
                    rd_ptr <= start_q + ADDR_W'(burst_len);
                    state  <= WAIT_REL;
                end
                WAIT_REL: begin
                    if (load_base) rd_ptr <= base_addr;
                    if (!mem_req) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_mem_reader.sv
// Self-checking bench for weight_mem_reader: directed and random bursts checked
// against a queue-based model of addresses, data, timing and the read pointer.
module tb_weight_mem_reader;
    import weight_mem_reader_pkg::*;

    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst_n;
    op_mode_e          mode_in;
    logic              mem_req;
    logic              load_base;
    logic [ADDR_W-1:0] base_addr;
    logic              flush;
    logic              sram_rd_en;
    logic [ADDR_W-1:0] sram_addr;
    logic [63:0]       sram_rdata;
    logic              mem_data_valid;
    logic [63:0]       weight_data;
    logic              busy;
    logic              burst_done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [63:0] mem [4096];

    logic [ADDR_W-1:0] addr_q[$];
    int                en_cyc_q[$];
    logic [63:0]       data_q[$];
    int                val_cyc_q[$];
    int                done_cyc_q[$];
    int                busy_cnt;

    logic [ADDR_W-1:0] model_ptr;
    logic [63:0]       last_word;

    weight_mem_reader dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mode_in        (mode_in),
        .mem_req        (mem_req),
        .load_base      (load_base),
        .base_addr      (base_addr),
        .flush          (flush),
        .sram_rd_en     (sram_rd_en),
        .sram_addr      (sram_addr),
        .sram_rdata     (sram_rdata),
        .mem_data_valid (mem_data_valid),
        .weight_data    (weight_data),
        .busy           (busy),
        .burst_done     (burst_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // One-cycle-latency SRAM model.
    always @(posedge clk) if (sram_rd_en) sram_rdata <= mem[sram_addr];

    always @(negedge clk) begin
        if (rst_n) begin
            if (sram_rd_en) begin
                addr_q.push_back(sram_addr);
                en_cyc_q.push_back(cyc);
            end
            if (mem_data_valid) begin
                data_q.push_back(weight_data);
                val_cyc_q.push_back(cyc);
            end
            if (burst_done) done_cyc_q.push_back(cyc);
            if (busy) busy_cnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int words_for(input op_mode_e m);
        case (m)
            MODE1:   return 88;
            MODE2:   return 44;
            MODE3:   return 22;
            default: return 0;
        endcase
    endfunction

    task automatic clear_mon();
        addr_q.delete();
        en_cyc_q.delete();
        data_q.delete();
        val_cyc_q.delete();
        done_cyc_q.delete();
        busy_cnt = 0;
    endtask

    task automatic do_burst(input op_mode_e m, input bit ld, input logic [ADDR_W-1:0] base,
                            input bit busy_ld, input bit drop_req);
        int n, t0, aerr, derr, waited;
        logic [ADDR_W-1:0] start;
        n     = words_for(m);
        start = ld ? base : model_ptr;
        clear_mon();
        @(posedge clk); #1;
        mode_in   = m;
        load_base = ld;
        base_addr = base;
        mem_req   = 1'b1;
        t0        = cyc;
        @(posedge clk); #1;
        load_base = 1'b0;
        base_addr = ADDR_W'($urandom);
        if (busy_ld || drop_req) begin
            @(posedge clk); #1;
            if (busy_ld) begin
                load_base = 1'b1;
                base_addr = ADDR_W'($urandom);
            end
            if (drop_req) mem_req = 1'b0;
            @(posedge clk); #1;
            load_base = 1'b0;
        end
        waited = 0;
        while (done_cyc_q.size() == 0 && waited < 300) begin
            @(posedge clk); #1;
            waited++;
        end
        repeat (4) @(posedge clk);
        #1;

        aerr = 0;
        for (int i = 0; i < addr_q.size(); i++)
            if (addr_q[i] !== start + ADDR_W'(i) || en_cyc_q[i] != t0 + 1 + i) aerr++;
        derr = 0;
        for (int i = 0; i < data_q.size(); i++)
            if (data_q[i] !== mem[start + ADDR_W'(i)] || val_cyc_q[i] != t0 + 3 + i) derr++;
        if (n > 0) last_word = mem[start + ADDR_W'(n - 1)];
        model_ptr = start + ADDR_W'(n);

        check("rd_en_count", 64'(addr_q.size()), 64'(n));
        check("addr_seq_errs", 64'(aerr), 64'd0);
        check("valid_count", 64'(data_q.size()), 64'(n));
        check("data_seq_errs", 64'(derr), 64'd0);
        check("done_count", 64'(done_cyc_q.size()), 64'd1);
        if (done_cyc_q.size() > 0)
            check("done_cycle", 64'(done_cyc_q[0]), 64'((n > 0) ? t0 + n + 2 : t0 + 1));
        check("busy_cycles", 64'(busy_cnt), 64'((n > 0) ? n + 2 : 1));
        check("data_hold", weight_data, last_word);

        mem_req = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int t0, derr;
        logic [ADDR_W-1:0] start;
        op_mode_e rm;

        for (int k = 0; k < 4096; k++) begin
            logic [7:0] kb;
            kb     = k[7:0];
            mem[k] = (k < 88) ? {8{kb}} : {$urandom, $urandom};
        end

        rst_n     = 1'b0;
        mode_in   = MODE_NONE;
        mem_req   = 1'b0;
        load_base = 1'b0;
        base_addr = '0;
        flush     = 1'b0;
        model_ptr = '0;
        last_word = '0;
        #1;
        check("rst_rd_en", 64'(sram_rd_en), 64'd0);
        check("rst_addr", 64'(sram_addr), 64'd0);
        check("rst_valid", 64'(mem_data_valid), 64'd0);
        check("rst_data", weight_data, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(burst_done), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // MODE1 from pointer 0 with the byte-replicated pattern.
        do_burst(MODE1, 1'b0, '0, 1'b0, 1'b0);
        if (data_q.size() == 88) check("last_word_5757", data_q[87], 64'h5757575757575757);

        // MODE3 continues at 88; then a wrapping burst from 0xFF8.
        do_burst(MODE3, 1'b0, '0, 1'b0, 1'b0);
        do_burst(MODE3, 1'b1, 12'hFF8, 1'b0, 1'b0);
        check("ptr_after_wrap", 64'(model_ptr), 64'h00E);
        do_burst(MODE2, 1'b0, '0, 1'b0, 1'b0);

        // Flush on the 10th FETCH cycle of a MODE1 burst.
        clear_mon();
        start = model_ptr;
        @(posedge clk); #1;
        mode_in = MODE1;
        mem_req = 1'b1;
        t0      = cyc;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("flush_rd_en", 64'(sram_rd_en), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        derr = 0;
        for (int i = 0; i < data_q.size(); i++)
            if (data_q[i] !== mem[start + ADDR_W'(i)] || val_cyc_q[i] != t0 + 3 + i) derr++;
        check("flush_issues", 64'(addr_q.size()), 64'd9);
        check("flush_valids", 64'(data_q.size()), 64'd8);
        check("flush_data_errs", 64'(derr), 64'd0);
        check("flush_no_done", 64'(done_cyc_q.size()), 64'd0);
        check("flush_busy_low", 64'(busy), 64'd0);
        mem_req = 1'b0;
        repeat (2) @(posedge clk);
        do_burst(MODE1, 1'b0, '0, 1'b0, 1'b0);

        // load_base while busy must not disturb the burst or the end pointer.
        do_burst(MODE2, 1'b0, '0, 1'b1, 1'b0);
        do_burst(MODE3, 1'b0, '0, 1'b0, 1'b0);

        // Reset during DRAIN.
        clear_mon();
        @(posedge clk); #1;
        mode_in = MODE3;
        mem_req = 1'b1;
        repeat (23) @(posedge clk);
        #1;
        check("drain_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rd_en", 64'(sram_rd_en), 64'd0);
        check("mid_rst_addr", 64'(sram_addr), 64'd0);
        check("mid_rst_valid", 64'(mem_data_valid), 64'd0);
        check("mid_rst_data", weight_data, 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(burst_done), 64'd0);
        mem_req = 1'b0;
        @(posedge clk); #1;
        rst_n     = 1'b1;
        model_ptr = '0;
        last_word = '0;
        clear_mon();
        repeat (6) @(posedge clk);
        #1;
        check("post_rst_quiet", 64'(data_q.size() + addr_q.size()), 64'd0);
        do_burst(MODE2, 1'b0, '0, 1'b0, 1'b0);

        // No-op burst from the unused mode encoding.
        do_burst(MODE_NONE, 1'b0, '0, 1'b0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            rm = op_mode_e'($urandom_range(0, 3));
            do_burst(rm, 1'($urandom_range(0, 1)), ADDR_W'($urandom),
                     (words_for(rm) > 0) && ($urandom_range(0, 1) == 1),
                     1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
